// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the CPU-side request/response handshake and the data-memory bus of
// mem_access_ctrl into one interface.
//
// Modports:
//   slave  - the controller: takes requests and read data, drives the response
//            and the memory strobes/address/write data.
//   master - the environment (CPU memory stage plus data memory): drives
//            requests and read data, observes the response and the memory bus.
//
// Signals:
//   req_valid/req_ready   request handshake
//   req_write/req_size/req_signed/req_addr/req_wdata   request fields
//   resp_valid/resp_rdata/resp_fault                   completion
//   mem_addr/mem_wdata/mem_write/mem_read/mem_rdata    word-wide memory bus
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_write;
    logic              mem_read;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store sequencer between the CPU memory stage and a word-wide data
// memory. Accepts one byte/halfword/word request at a time, performs sub-word
// stores as read-modify-write, and returns big-endian lane-extracted,
// sign/zero-extended load data.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_access_ctrl_if.slave (request, response and memory bus)
//
// Configuration macro: MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word requests complete with resp_fault and
//               issue no memory strobe.
//   undefined - resp_fault stays 0; misaligned low address bits are ignored.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_ctrl_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_offset;
    logic [15:0]       r_wdata;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_fault;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_write;
    logic              r_mem_read;

    logic              w_fault;
    logic [1:0]        w_offset;
    logic [7:0]        w_lane_byte;
    logic [15:0]       w_lane_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_fault = r_resp_fault;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_read   = r_mem_read;

    // Request decode: fault detection and the lane offset actually used.
    // Halfwords only look at addr[1] and words at no low bits, so a request
    // that is not faulted always lands on a naturally aligned lane.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_fault  = 1'b0;
        w_offset = 2'b00;
        if (bus.req_size == 2'b00) begin
            w_offset = bus.req_addr[1:0];
        end else if (bus.req_size == 2'b01) begin
            w_offset = {bus.req_addr[1], 1'b0};
        end
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
        if (bus.req_size == 2'b01) begin
            w_fault = bus.req_addr[0];
        end else if (bus.req_size[1]) begin
            w_fault = |bus.req_addr[1:0];
        end
`else
        w_fault = 1'b0;
`endif
    end

    // Big-endian lane extraction for loads and lane merge for sub-word stores,
    // both working on the word returned by memory during WAIT.
    always_comb begin
        w_lane_byte = 8'h00;
        case (r_offset)
            2'd0:    w_lane_byte = bus.mem_rdata[31:24];
            2'd1:    w_lane_byte = bus.mem_rdata[23:16];
            2'd2:    w_lane_byte = bus.mem_rdata[15:8];
            default: w_lane_byte = bus.mem_rdata[7:0];
        endcase
        w_lane_half = r_offset[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

        if (r_size[1]) begin
            w_load_data = bus.mem_rdata;
        end else if (r_size[0]) begin
            w_load_data = {{16{r_signed & w_lane_half[15]}}, w_lane_half};
        end else begin
            w_load_data = {{24{r_signed & w_lane_byte[7]}}, w_lane_byte};
        end

        w_merged = bus.mem_rdata;
        if (r_size == 2'b00) begin
            case (r_offset)
                2'd0:    w_merged[31:24] = r_wdata[7:0];
                2'd1:    w_merged[23:16] = r_wdata[7:0];
                2'd2:    w_merged[15:8]  = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_offset[1]) begin
            w_merged[15:0] = r_wdata;
        end else begin
            w_merged[31:16] = r_wdata;
        end
    end

    // Sequencer. Every output is a register loaded together with the state it
    // belongs to, so strobes are glitch-free and mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_signed     <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= 16'h0000;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_fault <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_write      <= bus.req_write;
                        r_size       <= bus.req_size;
                        r_signed     <= bus.req_signed;
                        r_offset     <= w_offset;
                        r_wdata      <= bus.req_wdata[15:0];
                        r_req_ready  <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_write && bus.req_size[1]) begin
                                // Full-word store needs no read; write it as given.
                                r_mem_wdata <= bus.req_wdata;
                                r_mem_write <= 1'b1;
                                r_state     <= S_WR;
                            end else begin
                                r_mem_read <= 1'b1;
                                r_state    <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    r_mem_read <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_write) begin
                        r_mem_wdata <= w_merged;
                        r_mem_write <= 1'b1;
                        r_state     <= S_WR;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WR: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= 32'h0;
                    r_mem_addr   <= '0;
                    r_mem_wdata  <= 32'h0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_resp_fault <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_mem_read   <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end
endmodule
